// File: rtl/mult_unit_if.sv
// Command/result bundle between the controller (master) and the multiply unit (slave).
// Carries the Start_mult / Mult_sign request, operands, HI/LO product and status.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start_mult;
  logic             Mult_sign;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Prod_hi;
  logic [WIDTH-1:0] Prod_lo;
  logic             Busy;
  logic             Done;

  modport master (
    output Start_mult, Mult_sign, A, B,
    input  Prod_hi, Prod_lo, Busy, Done
  );

  modport slave (
    input  Start_mult, Mult_sign, A, B,
    output Prod_hi, Prod_lo, Busy, Done
  );
endinterface

// File: rtl/mult_unit.sv
// Multi-cycle shift-add multiplier (signed/unsigned) producing a 2*WIDTH HI/LO product.
// Optional early termination on an exhausted multiplier: define MULT_EARLY_EXIT_EN.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mult_unit_if.slave mif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   prod_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [WIDTH-1:0]     mrem_reg;
  logic [CW-1:0]        cnt_reg;
  logic                 neg_reg;
  logic                 busy_reg;
  logic                 done_reg;

  logic [WIDTH-1:0]     op_mag [2];
  logic [WIDTH:0]       sum_next;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   mag_final;
  logic [WIDTH-1:0]     mrem_next;
  logic                 last_iter;

  // Operand magnitudes: negate only when signed and the sign bit is set;
  // the most negative value maps to 2^(WIDTH-1) as an unsigned magnitude.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mag
      logic [WIDTH-1:0] op;
      assign op         = (gi == 0) ? mif.A : mif.B;
      assign op_mag[gi] = (mif.Mult_sign && op[WIDTH-1]) ? (~op + WIDTH'(1)) : op;
    end
  endgenerate

  always_comb begin
    sum_next  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (mrem_reg[0] ? {1'b0, mcand_reg} : '0);
    acc_next  = {sum_next, acc_reg[WIDTH-1:1]};
    mrem_next = mrem_reg >> 1;
`ifdef MULT_EARLY_EXIT_EN
    // Remaining iterations would only shift zeros in; do them as one barrel shift.
    last_iter = (cnt_reg == CW'(WIDTH - 1)) || (mrem_next == '0);
    mag_final = acc_next >> (CW'(WIDTH - 1) - cnt_reg);
`else
    last_iter = (cnt_reg == CW'(WIDTH - 1));
    mag_final = acc_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      prod_reg  <= '0;
      mcand_reg <= '0;
      mrem_reg  <= '0;
      cnt_reg   <= '0;
      neg_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mif.Start_mult) begin
            mcand_reg <= op_mag[0];
            mrem_reg  <= op_mag[1];
            neg_reg   <= mif.Mult_sign & (mif.A[WIDTH-1] ^ mif.B[WIDTH-1]);
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg  <= acc_next;
          mrem_reg <= mrem_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (last_iter) begin
            prod_reg  <= neg_reg ? ('0 - mag_final) : mag_final;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mif.Prod_hi = prod_reg[2*WIDTH-1:WIDTH];
  assign mif.Prod_lo = prod_reg[WIDTH-1:0];
  assign mif.Busy    = busy_reg;
  assign mif.Done    = done_reg;
endmodule

// File: tb/tb_mult_unit.sv
// Randomized scoreboard bench for mult_unit: expected products and Done cycles are
// queued at issue time and checked by an independent negedge monitor.
module tb_mult_unit;
  typedef struct {
    logic [63:0] prod;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  bit   reset_q = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_from = 1;
  int   busy_to = 0;
  logic [63:0] last_prod = '0;
  exp_t sb[$];

  mult_unit_if #(.WIDTH(32)) mif ();

  mult_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .mif  (mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) reset_q <= reset;

  function automatic logic [63:0] ref_prod(logic [31:0] a, logic [31:0] b, logic s);
    longint sa;
    longint sbv;
    if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      return 64'(sa * sbv);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Number of RUN cycles: full width, or up to the top set bit of |B| with early exit.
  function automatic int ref_lat(logic [31:0] b, logic s);
    logic [31:0] m;
    int n;
    m = (s && b[31]) ? (~b + 32'd1) : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`ifndef MULT_EARLY_EXIT_EN
    n = 32;
`endif
    return n;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  // Monitor: checks status and results every cycle against the scoreboard.
  always @(negedge clk) begin
    logic [63:0] got;
    exp_t e;
    got = {mif.Prod_hi, mif.Prod_lo};
    if (reset_q) begin
      sb.delete();
      last_prod = '0;
      busy_from = 1;
      busy_to   = 0;
      chk("reset_busy", 64'(mif.Busy), 64'd0);
      chk("reset_done", 64'(mif.Done), 64'd0);
      chk("reset_prod", got, 64'd0);
    end else begin
      chk("busy", 64'(mif.Busy), 64'(cyc >= busy_from && cyc <= busy_to));
      if (mif.Done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 64'(mif.Done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("product", got, e.prod);
          last_prod = e.prod;
          $display("done cyc=%0d HI=%h LO=%h", cyc, mif.Prod_hi, mif.Prod_lo);
        end
      end else begin
        chk("hold", got, last_prod);
        if (sb.size() > 0 && cyc >= sb[0].done_cyc) begin
          chk("missing_done", 64'(mif.Done), 64'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Call at a negedge; Start_mult is sampled on the following posedge.
  task automatic issue(logic [31:0] a, logic [31:0] b, logic s, bit track);
    int c;
    int lat;
    exp_t e;
    c   = cyc;
    lat = ref_lat(b, s);
    mif.A          = a;
    mif.B          = b;
    mif.Mult_sign  = s;
    mif.Start_mult = 1'b1;
    if (track) begin
      e.prod     = ref_prod(a, b, s);
      e.done_cyc = c + 1 + lat;
      sb.push_back(e);
      busy_from = c + 1;
      busy_to   = c + lat;
    end
    $display("issue cyc=%0d A=%h B=%h sign=%0b tracked=%0b", c, a, b, s, track);
    @(posedge clk);
    #1;
    mif.Start_mult = 1'b0;
    mif.A          = $urandom;
    mif.B          = $urandom;
    mif.Mult_sign  = 1'($urandom);
  endtask

  task automatic wait_done(int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mif.Done !== 1'b1 && n < budget);
    if (mif.Done !== 1'b1) chk("done_timeout", 64'(mif.Done), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] edges [5];
    logic [31:0] a;
    logic [31:0] b;
    logic s;
    int c0;
    edges[0] = 32'h0000_0000;
    edges[1] = 32'h0000_0001;
    edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h8000_0000;
    edges[4] = 32'h7FFF_FFFF;

    reset          = 1'b1;
    mif.Start_mult = 1'b0;
    mif.Mult_sign  = 1'b0;
    mif.A          = '0;
    mif.B          = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(32'd7, 32'd6, 1'b0, 1'b1);
    wait_done(100);
    @(negedge clk);
    issue(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
    wait_done(100);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_done(100);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    wait_done(100);

    // Start while busy must be ignored; restart in the Done cycle is accepted.
    @(negedge clk);
    c0 = cyc + 1;
    issue(32'd3, 32'd4, 1'b0, 1'b1);
    while (cyc < c0 + 10) @(negedge clk);
    if (cyc <= busy_to) issue(32'd9, 32'd9, 1'b0, 1'b0);
    wait_done(100);
    issue(32'd9, 32'd9, 1'b0, 1'b1);
    wait_done(100);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        1:       begin a = 32'($urandom_range(0, 15)); b = 32'($urandom_range(0, 15)); end
        2:       begin a = edges[$urandom_range(0, 4)]; b = edges[$urandom_range(0, 4)]; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      s = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(a, b, s, 1'b1);
      wait_done(100);
    end

    // Reset mid-operation: held product 42, then abort a 100*100.
    @(negedge clk);
    issue(32'd7, 32'd6, 1'b0, 1'b1);
    wait_done(100);
    @(negedge clk);
    c0 = cyc + 1;
    issue(32'd100, 32'd100, 1'b0, 1'b1);
    while (cyc < c0 + 15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    issue(32'd5, 32'd1, 1'b0, 1'b1);
    wait_done(100);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
